// File: rtl/audio_pwm_out.sv
// -----------------------------------------------------------------------------
// audio_pwm_out
//
// Reading end of the sample address/data interface. Once per sample period it
// pulses sample_req to advance the ROM address and capture the returned byte.
// It scales the byte by a two-digit BCD volume and plays it out as an 8-bit,
// 256-clock PWM on a single audio pin.
//
// Optional feature: define SOFT_RAMP_EN to enable a soft volume ramp. With the
// ramp enabled, the gain moves one step per sample toward its target, and mute
// fades the output to midscale instead of cutting it.
//
// Ports
//   clk         in   1  system clock
//   reset       in   1  asynchronous, active-low reset
//   play        in   1  1 = playing, 0 = paused (output held at midscale)
//   mute        in   1  1 = silent midscale output, sample requests continue
//   volume1     in   4  volume tens digit, BCD (digits >9 read as 9)
//   volume0     in   4  volume units digit, BCD (digits >9 read as 9)
//   data        in   8  unsigned ROM sample, 128 = silence; valid 1 clk after sample_req
//   sample_req  out  1  one-clock pulse: address advance / sample consumed
//   duty        out  8  PWM compare value currently applied
//   pwm_out     out  1  PWM audio output
// -----------------------------------------------------------------------------
module audio_pwm_out #(
    parameter int PERIODS_PER_SAMPLE = 4    // PWM periods per sample, 1..16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play,
    input  logic       mute,
    input  logic [3:0] volume1,
    input  logic [3:0] volume0,
    input  logic [7:0] data,
    output logic       sample_req,
    output logic [7:0] duty,
    output logic       pwm_out
);

    typedef enum logic [1:0] {IDLE, CAPTURE, SCALE, HOLD} state_t;

    localparam logic [3:0] PER_LAST = 4'(PERIODS_PER_SAMPLE - 1);
    localparam logic [7:0] MIDSCALE = 8'd128;

    state_t             state_q, state_d;
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic [3:0]         per_cnt_q, per_cnt_d;
    logic               sample_req_q, sample_req_d;
    logic signed [8:0]  s_q, s_d;
    logic signed [15:0] p_q, p_d;
    logic [7:0]         pending_q, pending_d;
    logic [7:0]         duty_q, duty_d;
    logic               pwm_out_q, pwm_out_d;
`ifdef SOFT_RAMP_EN
    logic [6:0]         gain_eff_q, gain_eff_d;
    logic [6:0]         gain_tgt;
`endif

    logic [3:0]         vol_tens, vol_units;
    logic [6:0]         vol;
    logic [6:0]         gain;
    logic [6:0]         gain_use;
    logic signed [15:0] level;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so
        // that no path through the case statement can infer a latch.
        pwm_cnt_d    = pwm_cnt_q + 8'd1;
        per_cnt_d    = per_cnt_q;
        state_d      = state_q;
        s_d          = s_q;
        p_d          = p_q;
        pending_d    = pending_q;
        duty_d       = duty_q;
        pwm_out_d    = (pwm_cnt_q < duty_q);
        sample_req_d = 1'b0;
        level        = '0;

        // BCD digits above 9 saturate to 9; gain = (vol*165)>>7 maps 0..99 onto 0..127.
        vol_tens  = (volume1 > 4'd9) ? 4'd9 : volume1;
        vol_units = (volume0 > 4'd9) ? 4'd9 : volume0;
        vol       = 7'(vol_tens) * 7'd10 + 7'(vol_units);
        gain      = 7'((14'(vol) * 14'd165) >> 7);
`ifdef SOFT_RAMP_EN
        gain_eff_d = gain_eff_q;
        gain_tgt   = mute ? 7'd0 : gain;
        gain_use   = gain_eff_q;
`else
        gain_use   = gain;
`endif

        if (pwm_cnt_q == 8'hFF) begin
            per_cnt_d = (per_cnt_q == PER_LAST) ? 4'd0 : per_cnt_q + 4'd1;
            duty_d    = pending_q;     // duty only changes on the period wrap
        end

        case (state_q)
            IDLE: begin
                if (sample_req_q) state_d = CAPTURE;
            end
            CAPTURE: begin
                s_d     = $signed({1'b0, data}) - 9'sd128;
                state_d = SCALE;
            end
            SCALE: begin
                p_d     = 16'(s_q) * 16'($signed({1'b0, gain_use}));
                state_d = HOLD;
            end
            HOLD: begin
                level = (p_q >>> 7) + 16'sd128;
                if (level < 16'sd0)        pending_d = 8'd0;
                else if (level > 16'sd255) pending_d = 8'd255;
                else                       pending_d = level[7:0];
`ifdef SOFT_RAMP_EN
                if (gain_eff_q < gain_tgt)      gain_eff_d = gain_eff_q + 7'd1;
                else if (gain_eff_q > gain_tgt) gain_eff_d = gain_eff_q - 7'd1;
`else
                if (mute) pending_d = MIDSCALE;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Pause discards any sample in flight and parks the output at midscale.
        if (!play) begin
            state_d   = IDLE;
            pending_d = MIDSCALE;
        end

        // The request is registered, so it is decided one clock early: it is
        // high exactly in the cycle where pwm_cnt==0 and per_cnt==0.
        sample_req_d = play && (state_d == IDLE) && (pwm_cnt_q == 8'hFF)
                       && (per_cnt_q == PER_LAST);
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pwm_cnt_q    <= '0;
            per_cnt_q    <= '0;
            sample_req_q <= 1'b0;
            s_q          <= '0;
            p_q          <= '0;
            pending_q    <= MIDSCALE;
            duty_q       <= MIDSCALE;
            pwm_out_q    <= 1'b0;
`ifdef SOFT_RAMP_EN
            gain_eff_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pwm_cnt_q    <= pwm_cnt_d;
            per_cnt_q    <= per_cnt_d;
            sample_req_q <= sample_req_d;
            s_q          <= s_d;
            p_q          <= p_d;
            pending_q    <= pending_d;
            duty_q       <= duty_d;
            pwm_out_q    <= pwm_out_d;
`ifdef SOFT_RAMP_EN
            gain_eff_q   <= gain_eff_d;
`endif
        end
    end

    assign sample_req = sample_req_q;
    assign duty       = duty_q;
    assign pwm_out    = pwm_out_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// -----------------------------------------------------------------------------
// tb_audio_pwm_out
//
// Scoreboard bench for audio_pwm_out (default build, PERIODS_PER_SAMPLE = 4).
// The stimulus process applies directed vectors and pushes the hand-computed
// duty for each sample. The monitor process pops one entry per sample_req. It
// checks the request spacing, the 256-clock sample-to-duty latency and the
// new duty value.
// -----------------------------------------------------------------------------
module tb_audio_pwm_out;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic       mute;
    logic [3:0] volume1;
    logic [3:0] volume0;
    logic [7:0] data;
    logic       sample_req;
    logic [7:0] duty;
    logic       pwm_out;

    audio_pwm_out #(.PERIODS_PER_SAMPLE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .mute       (mute),
        .volume1    (volume1),
        .volume0    (volume0),
        .data       (data),
        .sample_req (sample_req),
        .duty       (duty),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_exp = 8'd128;
    bit         have_prev = 1'b0;
    int unsigned prev_cyc = 0;

    typedef struct {
        logic [3:0] v1;
        logic [3:0] v0;
        logic [7:0] d;
        logic       m;
        logic [7:0] e;
    } vec_t;

    // Expected duty = clip8(floor((data-128)*gain / 128) + 128), gain = (vol*165)>>7.
    vec_t vecs[13] = '{
        '{4'd9,  4'd9,  8'd255, 1'b0, 8'd254},
        '{4'd9,  4'd9,  8'd255, 1'b0, 8'd254},
        '{4'd5,  4'd0,  8'd0,   1'b0, 8'd64 },
        '{4'd5,  4'd0,  8'd255, 1'b0, 8'd191},
        '{4'd0,  4'd0,  8'd0,   1'b0, 8'd128},
        '{4'd9,  4'd9,  8'd128, 1'b0, 8'd128},
        '{4'd2,  4'd5,  8'd64,  1'b0, 8'd112},
        '{4'd9,  4'd9,  8'd127, 1'b0, 8'd127},
        '{4'd0,  4'd1,  8'd0,   1'b0, 8'd127},
        '{4'd15, 4'd15, 8'd0,   1'b0, 8'd1  },
        '{4'd9,  4'd9,  8'd255, 1'b1, 8'd128},
        '{4'd9,  4'd9,  8'd255, 1'b1, 8'd128},
        '{4'd9,  4'd9,  8'd255, 1'b0, 8'd254}
    };

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Bounded wait for a request, observed on the falling edge.
    task automatic wait_req(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sample_req !== 1'b1 && n < budget);
        check("req_seen", int'(sample_req === 1'b1), 1);
    endtask

    task automatic count_reqs(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (sample_req === 1'b1) cnt++;
        end
    endtask

    // Monitor: one scoreboard entry per sample_req.
    initial begin
        logic [7:0] exp_duty;
        forever begin
            @(negedge clk);
            if (sample_req === 1'b1) begin
                if (have_prev) check("req_period", int'(cyc - prev_cyc), 1024);
                prev_cyc  = cyc;
                have_prev = 1'b1;
                if (exp_q.size() == 0) begin
                    check("sb_has_expected", exp_q.size(), 1);
                end else begin
                    exp_duty = exp_q.pop_front();
                    @(negedge clk);
                    check("req_pulse_width", int'(sample_req), 0);
                    repeat (254) @(negedge clk);
                    check("duty_before_latency", duty, last_exp);
                    @(negedge clk);
                    check("duty_update", duty, exp_duty);
                    last_exp = exp_duty;
                end
            end
        end
    end

    // Stimulus
    initial begin
        int cnt;

        reset = 1'b0; play = 1'b1; mute = 1'b0;
        volume1 = 4'd9; volume0 = 4'd9; data = 8'd255;
        repeat (3) @(negedge clk);
        check("rst_duty", duty, 128);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_sample_req", int'(sample_req), 0);

        play  = 1'b0;
        reset = 1'b1;
        count_reqs(5000, cnt);
        check("paused_no_req", cnt, 0);

        play = 1'b1;
        foreach (vecs[i]) begin
            volume1 = vecs[i].v1;
            volume0 = vecs[i].v0;
            data    = vecs[i].d;
            mute    = vecs[i].m;
            exp_q.push_back(vecs[i].e);
            wait_req(1100);
            repeat (300) @(negedge clk);
            if (i == 1) begin
                cnt = 0;
                for (int k = 0; k < 256; k++) begin
                    @(negedge clk);
                    if (pwm_out === 1'b1) cnt++;
                end
                check("pwm_high_count", cnt, 254);
            end
        end

        // Pause while the sample is in CAPTURE: the sample is dropped and
        // the duty goes to midscale at the next wrap.
        exp_q.push_back(8'd128);
        wait_req(1100);
        @(negedge clk);
        play = 1'b0;
        repeat (300) @(negedge clk);
        count_reqs(3000, cnt);
        check("pause_no_req", cnt, 0);
        check("pause_duty", duty, 128);

        // Resume, then reset in the middle of a PWM period.
        have_prev = 1'b0;
        exp_q.push_back(8'd254);
        play = 1'b1;
        wait_req(1100);
        repeat (300) @(negedge clk);
        play = 1'b0;
        check("pre_reset_duty", duty, 254);
        check("pre_reset_pwm_out", int'(pwm_out), 1);
        reset = 1'b0;
        #1;
        check("mid_reset_duty", duty, 128);
        check("mid_reset_pwm_out", int'(pwm_out), 0);
        check("mid_reset_sample_req", int'(sample_req), 0);
        repeat (5) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
